// File: rtl/common.sv
// Shared data-bus transaction types for the physical data bus.
//   dbus_req_t  : valid, addr, size, strobe, data (nonzero strobe = write)
//   dbus_resp_t : addr_ok, data_ok, data
package common;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

endpackage

// File: rtl/dbus_sram_responder_pkg.sv
// Package for the data-bus SRAM responder: FSM state encoding and the data
// word returned for out-of-range reads when DBUS_RESP_RANGECHK_EN is defined.
package dbus_responder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } dresp_state_t;

  localparam logic [31:0] RANGE_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/dbus_sram_responder_if.sv
// Data-bus interface between a requester (master) and the SRAM responder
// (slave).
//   dreq    : request, driven by the master
//   dresp   : response, driven by the slave
//   bus_err : out-of-range flag, exists only when DBUS_RESP_RANGECHK_EN is
//             defined
interface dbus_sram_responder_if;
  import common::*;

  dbus_req_t  dreq;
  dbus_resp_t dresp;

`ifdef DBUS_RESP_RANGECHK_EN
  logic bus_err;

  modport master (output dreq, input dresp, input bus_err);
  modport slave  (input dreq, output dresp, output bus_err);
`else
  modport master (output dreq, input dresp);
  modport slave  (input dreq, output dresp);
`endif

endinterface

// File: rtl/dbus_sram_responder_sram.sv
// sram_1rw_be: single-port 32-bit word array with per-byte write enables and
// a registered read. Contents have no reset and survive system reset.
//   clk     : clock
//   en_i    : access enable for this cycle
//   we_i    : per-byte write enables; all-zero means read
//   addr_i  : word index
//   wdata_i : write data
//   rdata_o : read data, valid the cycle after a read access
module sram_1rw_be #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int i = 0; i < 4; i++) begin
        if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
      if (we_i == 4'b0000) rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dbus_sram_responder.sv
// dbus_sram_responder: terminating data-bus endpoint backed by a local SRAM.
// One outstanding transaction; each passes through WAIT_CYCLES idle cycles
// before the SRAM access. Optional macro DBUS_RESP_RANGECHK_EN enables
// out-of-range detection (suppressed write, DEAD_BEEF read, bus_err pulse);
// without it addresses wrap modulo DEPTH_WORDS.
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : slave side of the data-bus interface (dreq in, dresp/bus_err out)
//
// state  | meaning
// IDLE   | addr_ok follows valid; request latched on valid
// WAIT   | wait-state countdown
// ACCESS | SRAM read/write with the latched fields
// RESP   | data_ok for one cycle, read data or zero
module dbus_sram_responder
  import common::*;
  import dbus_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic                   clk,
  input logic                   reset,
  dbus_sram_responder_if.slave  bus
);

  localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  dresp_state_t state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [31:0]  addr_q, addr_d;
  logic [3:0]   strobe_q, strobe_d;
  logic [31:0]  wdata_q, wdata_d;

  logic [31:0]  offset;
  logic [AW-1:0] idx;
  logic         range_err;
  logic         sram_go;
  logic [3:0]   sram_we;
  logic [31:0]  sram_rdata;
  logic         data_ok;
  dbus_resp_t   resp;
  logic         unused_bits;

  assign offset = addr_q - BASE_ADDR;
  assign idx    = offset[AW+1:2];

`ifdef DBUS_RESP_RANGECHK_EN
  // 33-bit compare so the limit cannot overflow; underflow lands high.
  assign range_err   = ({1'b0, offset} >= (33'(DEPTH_WORDS) << 2));
`else
  assign range_err   = 1'b0;
`endif

  assign unused_bits = ^{bus.dreq.size, offset[1:0], offset[31:AW+2]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    strobe_d = strobe_q;
    wdata_d  = wdata_q;
    sram_go  = 1'b0;
    data_ok  = 1'b0;
    resp     = '0;
    unique case (state_q)
      IDLE: begin
        resp.addr_ok = bus.dreq.valid;
        if (bus.dreq.valid) begin
          addr_d   = bus.dreq.addr;
          strobe_d = bus.dreq.strobe;
          wdata_d  = bus.dreq.data;
          cnt_d    = WAIT_LOAD;
          state_d  = (WAIT_CYCLES > 0) ? WAIT : ACCESS;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ACCESS: begin
        sram_go = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        data_ok = ~reset;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    resp.data_ok = data_ok;
    if (data_ok && (strobe_q == 4'b0000)) begin
      resp.data = range_err ? RANGE_ERR_DATA : sram_rdata;
    end
  end

  assign bus.dresp = resp;
`ifdef DBUS_RESP_RANGECHK_EN
  assign bus.bus_err = data_ok & range_err;
`endif

  // Reset on the ACCESS edge must not let a write reach the array.
  assign sram_we = (sram_go && !reset && !range_err) ? strobe_q : 4'b0000;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= 32'h0;
      strobe_q <= 4'h0;
      wdata_q  <= 32'h0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      strobe_q <= strobe_d;
      wdata_q  <= wdata_d;
    end
  end

  sram_1rw_be #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_sram (
    .clk     (clk),
    .en_i    (sram_go & ~reset),
    .we_i    (sram_we),
    .addr_i  (idx),
    .wdata_i (wdata_q),
    .rdata_o (sram_rdata)
  );

endmodule

// File: doc/dbus_sram_responder.md
# dbus_sram_responder

Terminating responder for the physical data bus: accepts `dbus_req_t` transactions issued after address translation and answers them with `dbus_resp_t` from a local word-addressed SRAM. Each transaction passes through a programmable wait-state delay. It serves as the data-side endpoint for bring-up and unit benches, in place of the cache and AXI path. It handles one outstanding transaction, byte-strobed writes and whole-word reads.

## Interface
- `DEPTH_WORDS`, 1024: SRAM depth in 32-bit words; power of two.
- `WAIT_CYCLES`, 2: idle cycles between acceptance and the memory access; range 0..15.
- `BASE_ADDR`, 32'h0000_0000: physical address mapped to word 0.
- `clk`  in  1: sole clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `dreq`  in  `dbus_req_t`: request (`valid`, `addr`, `size`, `strobe`, `data`); a nonzero `strobe` marks a write.
- `dresp`  out  `dbus_resp_t`: response (`addr_ok`, `data_ok`, `data`).
- `bus_err`  out  1: out-of-range flag, present only with `DBUS_RESP_RANGECHK_EN`.

## Operation
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE:
  - `addr_ok` = `dreq.valid`, combinationally.
  - On `valid`, latch `addr`, `strobe` and `data` into holding registers.
  - Next state is WAIT when `WAIT_CYCLES`>0, otherwise ACCESS. The wait counter loads `WAIT_CYCLES`-1.
- WAIT: the counter decrements each cycle. When it reaches 0, go to ACCESS.
- ACCESS: issue the SRAM access using the latched fields.
  - Index = ((addr − BASE_ADDR) >> 2) mod DEPTH_WORDS, computed as unsigned 32-bit arithmetic and truncated to log2(DEPTH_WORDS) bits.
  - Write: byte lane i is updated iff `strobe[i]`.
  - Read: the full word is fetched, with one-cycle SRAM read latency.
  - Go to RESP.
- RESP:
  - `data_ok`=1 for exactly one cycle.
  - `data` = word read, or 32'h0 for a write.
  - Go to IDLE.
- `addr_ok` is 0 in every state other than IDLE.
- `data_ok` is 1 only in RESP.
- `data` is 32'h0 whenever `data_ok`=0.
- `dreq` is ignored outside IDLE; the requester is not required to hold it after `addr_ok`.
- `size` is not interpreted. Byte selection is entirely by `strobe`; sub-word reads return the whole aligned word. `addr[1:0]` is ignored for indexing.
- SRAM contents are not initialised by reset and survive reset.

## Timing
- Reset values: state=IDLE, counter=0, holding registers=0. `dresp.addr_ok`=0 unless `valid`, `dresp.data_ok`=0, `dresp.data`=32'h0, `bus_err`=0.
- Latency:
  - Acceptance occurs in cycle 0, when `valid` and `addr_ok` are both high in IDLE.
  - `data_ok` is asserted in cycle `WAIT_CYCLES`+2.
  - With `WAIT_CYCLES`=0, `data_ok` is asserted in cycle 2.
- Back-to-back: the earliest next acceptance is the cycle after RESP. Peak throughput is 1 per `WAIT_CYCLES`+3 cycles.
- A write followed by a read of the same word returns the written data; there is no bypass, and none is needed.
- Reset asserted in any state:
  - Return to IDLE on the next edge and drop the pending transaction; no `data_ok` is issued.
  - A write whose ACCESS edge coincides with reset is suppressed.
- `valid` asserted together with `reset` is not accepted.

## Configuration
- `DBUS_RESP_RANGECHK_EN` defined:
  - An address is out of range when (addr − BASE_ADDR) ≥ 4·DEPTH_WORDS, unsigned, which covers underflow.
  - For such an address the write is suppressed and the read returns 32'hDEAD_BEEF.
  - `bus_err` pulses for one cycle, coincident with `data_ok`.
- Undefined: the `bus_err` port is absent and out-of-range addresses wrap modulo DEPTH_WORDS.

## Structure
- The shared package `dbus_responder_pkg` holds:
  - the `dresp_state_t` enum (IDLE, WAIT, ACCESS, RESP);
  - the `RANGE_ERR_DATA` = 32'hDEAD_BEEF constant.
- `dbus_req_t` and `dbus_resp_t` are reused from `common`.
- The storage is one sub-module, `sram_1rw_be`: a single-port array with per-byte write enable, parameterised by depth, with a registered read.

## Test plan
- Write 32'h1122_3344 to 0x0000_0010 with strobe 4'hF, then read 0x10 -> read `data_ok` at cycle 4 after acceptance (`WAIT_CYCLES`=2) with `data`=32'h1122_3344.
- After the first scenario, write 32'hAABB_CCDD to 0x12 with strobe 4'b0100, then read 0x10 -> 32'h11BB_3344.
- With `WAIT_CYCLES`=0, issue a read held high continuously -> `addr_ok` once every 3 cycles, `data_ok` two cycles after each acceptance, never overlapping.
- Assert reset during WAIT of a write of 32'hFFFF_FFFF to 0x20 (old value 32'h0) -> no `data_ok`, all outputs at reset values; a later read of 0x20 returns 32'h0.
- With `DBUS_RESP_RANGECHK_EN`, `DEPTH_WORDS`=1024, `BASE_ADDR`=32'h1000: read 0x0FFC -> `data`=32'hDEAD_BEEF with `bus_err`=1; read 0x1FFC -> stored data with `bus_err`=0.
- Without the macro, write 32'h5A5A_5A5A to 0x1000+4096 (`BASE_ADDR`=32'h1000) -> a read of 0x1000 returns 32'h5A5A_5A5A.
